// File: rtl/z80_mem_cycle_master_if.sv
// Request/response and Z80 memory-bus signals for z80_mem_cycle_master.
// master: the cycle generator; slave: the requester plus the bus target it talks to.
interface z80_mem_cycle_master_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              REQ_VALID;
   logic              REQ_READY;
   logic              REQ_WR;
   logic [ADDR_W-1:0] REQ_ADDR;
   logic [DATA_W-1:0] REQ_WDATA;
   logic              RSP_VALID;
   logic [DATA_W-1:0] RSP_RDATA;
   logic              RSP_TIMEOUT;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] D_OUT;
   logic              D_OE;
   logic [DATA_W-1:0] D_IN;
   logic              MREQ_N;
   logic              RD_N;
   logic              WR_N;
   logic              WAIT_N;
   logic              BUSY;

   modport master (
      input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, D_IN, WAIT_N,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
             Addr, D_OUT, D_OE, MREQ_N, RD_N, WR_N, BUSY
   );

   modport slave (
      output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, D_IN, WAIT_N,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
             Addr, D_OUT, D_OE, MREQ_N, RD_N, WR_N, BUSY
   );
endinterface

// File: rtl/z80_mem_cycle_master.sv
// Z80-style memory read/write cycle initiator (T1/T2/[TW]/T3), one T-state per CLK.
// Define Z80_WAIT_STATE_EN to honour WAIT_N, insert TW states and report RSP_TIMEOUT.
module z80_mem_cycle_master #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   z80_mem_cycle_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_TW,
      S_T3
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic              r_busy;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_dout;
   logic              r_doe;
   logic              r_mreq_n;
   logic              r_rd_n;
   logic              r_wr_n;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rsp_valid;
   logic              w_accept;

`ifdef Z80_WAIT_STATE_EN
   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0]  r_wcnt;
   logic              r_to;
   logic              r_rsp_to;
`else
   logic              w_unused_wait;
   assign w_unused_wait = bus.WAIT_N;
`endif

   assign w_accept = bus.REQ_VALID & r_ready;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_dout      <= '0;
         r_doe       <= 1'b0;
         r_mreq_n    <= 1'b1;
         r_rd_n      <= 1'b1;
         r_wr_n      <= 1'b1;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
`ifdef Z80_WAIT_STATE_EN
         r_wcnt      <= '0;
         r_to        <= 1'b0;
         r_rsp_to    <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
`ifdef Z80_WAIT_STATE_EN
         r_rsp_to    <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            S_T1: begin
               r_state  <= S_T2;
               r_mreq_n <= 1'b0;
               r_rd_n   <= r_wr;
            end
            S_T2: begin
`ifdef Z80_WAIT_STATE_EN
               if (!bus.WAIT_N && (MAX_WAIT != 0)) begin
                  r_state <= S_TW;
                  r_wcnt  <= CNT_W'(1);
               end else begin
                  r_state <= S_T3;
                  r_ready <= 1'b1;
                  r_wr_n  <= ~r_wr;
                  r_to    <= ~bus.WAIT_N;
               end
`else
               r_state <= S_T3;
               r_ready <= 1'b1;
               r_wr_n  <= ~r_wr;
`endif
            end
`ifdef Z80_WAIT_STATE_EN
            S_TW: begin
               // Counter tracks the TW cycle in progress; the limit bounds it, so no wrap.
               if (bus.WAIT_N || (r_wcnt >= CNT_W'(MAX_WAIT))) begin
                  r_state <= S_T3;
                  r_ready <= 1'b1;
                  r_wr_n  <= ~r_wr;
                  r_to    <= ~bus.WAIT_N;
               end else begin
                  r_wcnt  <= r_wcnt + CNT_W'(1);
               end
            end
`endif
            S_T3: begin
               r_rsp_valid <= 1'b1;
`ifdef Z80_WAIT_STATE_EN
               r_rsp_to    <= r_to;
`endif
               if (!r_wr) begin
                  r_rdata <= bus.D_IN;
               end
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_mreq_n <= 1'b1;
               r_rd_n   <= 1'b1;
               r_wr_n   <= 1'b1;
               r_doe    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Accept is only possible in IDLE or T3 (READY high); it overrides those branches.
         if (w_accept) begin
            r_state  <= S_T1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_wr     <= bus.REQ_WR;
            r_addr   <= bus.REQ_ADDR;
            r_doe    <= bus.REQ_WR;
            r_mreq_n <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            if (bus.REQ_WR) begin
               r_dout <= bus.REQ_WDATA;
            end
`ifdef Z80_WAIT_STATE_EN
            r_wcnt   <= '0;
            r_to     <= 1'b0;
`endif
         end
      end
   end

   assign bus.REQ_READY   = r_ready;
   assign bus.BUSY        = r_busy;
   assign bus.Addr        = r_addr;
   assign bus.D_OUT       = r_dout;
   assign bus.D_OE        = r_doe;
   assign bus.MREQ_N      = r_mreq_n;
   assign bus.RD_N        = r_rd_n;
   assign bus.WR_N        = r_wr_n;
   assign bus.RSP_VALID   = r_rsp_valid;
   assign bus.RSP_RDATA   = r_rdata;
`ifdef Z80_WAIT_STATE_EN
   assign bus.RSP_TIMEOUT = r_rsp_to;
`else
   assign bus.RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_z80_mem_cycle_master.sv
// Bench for z80_mem_cycle_master: scoreboard of expected responses plus a WAIT_N-driving bus target.
// Wait-state expectations follow Z80_WAIT_STATE_EN.
module tb_z80_mem_cycle_master;

`ifdef Z80_WAIT_STATE_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif
   localparam int MAXW = 15;

   typedef struct {
      logic [7:0] rdata;
      logic       to;
      int         lat;
      int         acc;
   } item_t;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       tb_wait_n = 1'b1;
   logic [7:0] tb_d_in = 8'h00;
   int         wait_cfg = 0;
   int         wcnt = 0;
   logic       prev_mreq = 1'b1;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] last_rd = 8'h00;
   item_t      sb[$];
   item_t      mon_it;

   z80_mem_cycle_master_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   z80_mem_cycle_master #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   assign bus.WAIT_N = tb_wait_n;
   assign bus.D_IN   = tb_d_in;

   always #5 CLK = ~CLK;

   // Monitor: invariants, response scoreboard, and the WAIT_N-holding target.
   always @(posedge CLK) begin
      #1;
      cyc++;
      checks++;
      if ({bus.RD_N, bus.WR_N} === 2'b00) begin
         errors++;
         $display("FAIL inv_rd_wr: RD_N=%b WR_N=%b, required not both 0", bus.RD_N, bus.WR_N);
      end
      checks++;
      if ((bus.RD_N === 1'b0 || bus.WR_N === 1'b0) && bus.MREQ_N !== 1'b0) begin
         errors++;
         $display("FAIL inv_mreq: MREQ_N=%b with strobe active, required 0", bus.MREQ_N);
      end
      checks++;
      if (bus.RD_N === 1'b0 && bus.D_OE !== 1'b0) begin
         errors++;
         $display("FAIL inv_doe: D_OE=%b while RD_N=0, required 0", bus.D_OE);
      end
      if (bus.RSP_VALID === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: RSP_VALID=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_it = sb.pop_front();
            checks++;
            if (bus.RSP_RDATA !== mon_it.rdata) begin
               errors++;
               $display("FAIL rsp_rdata: got %h expected %h", bus.RSP_RDATA, mon_it.rdata);
            end
            checks++;
            if (bus.RSP_TIMEOUT !== mon_it.to) begin
               errors++;
               $display("FAIL rsp_timeout: got %b expected %b", bus.RSP_TIMEOUT, mon_it.to);
            end
            checks++;
            if ((cyc - mon_it.acc) !== mon_it.lat) begin
               errors++;
               $display("FAIL rsp_latency: got %0d expected %0d", cyc - mon_it.acc, mon_it.lat);
            end
         end
      end else begin
         checks++;
         if (bus.RSP_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL timeout_qual: RSP_TIMEOUT=%b without RSP_VALID, required 0", bus.RSP_TIMEOUT);
         end
      end
      if (bus.MREQ_N !== 1'b0) wcnt = 0;
      else if (prev_mreq === 1'b1) wcnt = wait_cfg;
      else if (wcnt > 0) wcnt--;
      tb_wait_n = (wcnt == 0);
      prev_mreq = bus.MREQ_N;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #3;
   endtask

   // Presents a request, waits (bounded) for READY, pushes the expectation; returns in T1.
   task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input int waits, input bit hold);
      item_t it;
      int n;
      int w;
      bus.REQ_VALID = 1'b1;
      bus.REQ_WR    = wr;
      bus.REQ_ADDR  = a;
      bus.REQ_WDATA = wd;
      wait_cfg      = waits;
      if (!wr) tb_d_in = rd;
      n = 0;
      while (bus.REQ_READY !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (bus.REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: REQ_READY=%b after %0d cycles, required 1", bus.REQ_READY, n);
         bus.REQ_VALID = 1'b0;
         return;
      end
      w = (waits > MAXW) ? MAXW : waits;
      it.rdata = wr ? last_rd : rd;
      if (!wr) last_rd = rd;
      it.to  = WEN && (waits > MAXW);
      it.lat = 4 + (WEN ? w : 0);
      it.acc = cyc;
      sb.push_back(it);
      tick();
      if (!hold) bus.REQ_VALID = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.BUSY !== 1'b0) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL drain: pending=%0d BUSY=%b, required 0 and 0", sb.size(), bus.BUSY);
      end
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.REQ_READY, bus.BUSY, bus.RSP_VALID, bus.RSP_TIMEOUT} !== 8'b1110_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 11100000",
                  {bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.REQ_READY, bus.BUSY, bus.RSP_VALID, bus.RSP_TIMEOUT});
      end
      checks++;
      if ({bus.Addr, bus.D_OUT, bus.RSP_RDATA} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00000000", {bus.Addr, bus.D_OUT, bus.RSP_RDATA});
      end
      RESET_N = 1'b1;
      tick();
      checks++;
      if ({bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.REQ_READY, bus.BUSY} !== 6'b111010) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected 111010",
                  {bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.REQ_READY, bus.BUSY});
      end
   endtask

   task automatic test_read();
      issue(1'b0, 16'hB800, 8'h00, 8'h5A, 0, 1'b0);
      checks++;
      if (bus.Addr[15:11] !== 5'b10111) begin
         errors++;
         $display("FAIL read_t1_addr: got %b expected 10111", bus.Addr[15:11]);
      end
      checks++;
      if ({bus.Addr, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.BUSY} !== {16'hB800, 5'b11101}) begin
         errors++;
         $display("FAIL read_t1: got %h expected %h",
                  {bus.Addr, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.BUSY}, {16'hB800, 5'b11101});
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE} !== 4'b0010) begin
            errors++;
            $display("FAIL read_t%0d_strobes: got %b expected 0010", i + 2,
                     {bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE});
         end
      end
      tick();
      tb_d_in = 8'hEE;
      checks++;
      if ({bus.Addr, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE} !== {16'hB800, 4'b1110}) begin
         errors++;
         $display("FAIL read_idle: got %h expected %h",
                  {bus.Addr, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE}, {16'hB800, 4'b1110});
      end
      drain();
   endtask

   task automatic test_write();
      logic [3:0] exp_s [3];
      exp_s[0] = 4'b1111;
      exp_s[1] = 4'b1011;
      exp_s[2] = 4'b1010;
      issue(1'b1, 16'hFFFF, 8'hC3, 8'h00, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.D_OE, bus.D_OUT, bus.MREQ_N, bus.RD_N, bus.WR_N} !== {exp_s[i][3], 8'hC3, exp_s[i][2:0]}) begin
            errors++;
            $display("FAIL write_t%0d: got %h expected %h", i + 1,
                     {bus.D_OE, bus.D_OUT, bus.MREQ_N, bus.RD_N, bus.WR_N}, {exp_s[i][3], 8'hC3, exp_s[i][2:0]});
         end
         tick();
      end
      checks++;
      if ({bus.D_OE, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.Addr} !== {4'b0111, 16'hFFFF}) begin
         errors++;
         $display("FAIL write_idle: got %h expected %h",
                  {bus.D_OE, bus.MREQ_N, bus.RD_N, bus.WR_N, bus.Addr}, {4'b0111, 16'hFFFF});
      end
      drain();
   endtask

   task automatic test_wait_states();
      int wl [3];
      int n;
      int exp_low;
      wl[0] = 2;
      wl[1] = MAXW;
      wl[2] = 1000;
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, 16'h1230 + 16'(k), 8'h00, 8'h40 + 8'(k), wl[k], 1'b0);
         exp_low = 2 + (WEN ? ((wl[k] > MAXW) ? MAXW : wl[k]) : 0);
         n = 0;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.MREQ_N !== 1'b0) break;
            n++;
         end
         checks++;
         if (n !== exp_low) begin
            errors++;
            $display("FAIL wait_mreq_cycles[%0d]: got %0d expected %0d", wl[k], n, exp_low);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      int n;
      issue(1'b0, 16'h4000, 8'h00, 8'hA5, 0, 1'b1);
      bus.REQ_WR    = 1'b1;
      bus.REQ_ADDR  = 16'h4001;
      bus.REQ_WDATA = 8'h3C;
      n = 0;
      while (bus.REQ_READY !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if ({n, bus.MREQ_N, bus.RD_N} !== {32'd2, 2'b00}) begin
         errors++;
         $display("FAIL b2b_accept_in_t3: got cycles=%0d MREQ_N=%b RD_N=%b expected 2 0 0", n, bus.MREQ_N, bus.RD_N);
      end
      issue(1'b1, 16'h4001, 8'h3C, 8'h00, 0, 1'b0);
      checks++;
      if ({bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.Addr} !== {4'b1111, 16'h4001}) begin
         errors++;
         $display("FAIL b2b_next_t1: got %h expected %h",
                  {bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.Addr}, {4'b1111, 16'h4001});
      end
      checks++;
      if ({bus.RSP_VALID, bus.RSP_RDATA} !== {1'b1, 8'hA5}) begin
         errors++;
         $display("FAIL b2b_first_rsp: got %h expected %h", {bus.RSP_VALID, bus.RSP_RDATA}, {1'b1, 8'hA5});
      end
      drain();
   endtask

   task automatic test_reset_mid_cycle();
      issue(1'b0, 16'h2222, 8'h00, 8'h77, 1000, 1'b0);
      tick();
      tick();
      RESET_N = 1'b0;
      sb.delete();
      last_rd = 8'h00;
      #1;
      checks++;
      if ({bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.BUSY, bus.RSP_VALID, bus.REQ_READY} !== 7'b1110000) begin
         errors++;
         $display("FAIL reset_abort: got %b expected 1110000",
                  {bus.MREQ_N, bus.RD_N, bus.WR_N, bus.D_OE, bus.BUSY, bus.RSP_VALID, bus.REQ_READY});
      end
      tick();
      tick();
      RESET_N = 1'b1;
      tick();
      checks++;
      if ({bus.REQ_READY, bus.BUSY, bus.MREQ_N} !== 3'b101) begin
         errors++;
         $display("FAIL reset_release: got %b expected 101", {bus.REQ_READY, bus.BUSY, bus.MREQ_N});
      end
      for (int i = 0; i < 6; i++) tick();
      issue(1'b0, 16'h0F0F, 8'h00, 8'h99, 0, 1'b0);
      drain();
   endtask

   initial begin
      bus.REQ_VALID = 1'b0;
      bus.REQ_WR    = 1'b0;
      bus.REQ_ADDR  = 16'h0000;
      bus.REQ_WDATA = 8'h00;
      test_reset();
      test_read();
      test_write();
      test_wait_states();
      test_back_to_back();
      test_reset_mid_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80_mem_cycle_master.md
Name: z80_mem_cycle_master

Overview:
- Bus initiator for the Laser 310 64K RAM expansion bus.
- Turns simple request/response transactions into Z80-style memory read and write cycles on Addr/MREQ_N/RD_N/WR_N/data.
- Serves as the driving end for the RAM chip-select/OE/WE decoder: a test master in simulation, or a DMA-style helper on the CPLD.
- One T-state per CLK cycle.

Parameters:
- ADDR_W, 16, width of request address and Addr bus.
- DATA_W, 8, width of data path.
- MAX_WAIT, 15, maximum wait states inserted before forced cycle completion (4-bit counter at default).

Ports:
- CLK  input  1  bus clock; one T-state per rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  master can accept a request this cycle.
- REQ_WR  input  1  1 = write, 0 = read.
- REQ_ADDR  input  ADDR_W  target address.
- REQ_WDATA  input  DATA_W  write data.
- RSP_VALID  output  1  one-cycle pulse: cycle complete.
- RSP_RDATA  output  DATA_W  read data; holds until next read completes.
- RSP_TIMEOUT  output  1  qualifies RSP_VALID; wait limit hit.
- Addr  output  ADDR_W  bus address.
- D_OUT  output  DATA_W  bus write data.
- D_OE  output  1  data bus drive enable.
- D_IN  input  DATA_W  bus read data.
- MREQ_N  output  1  memory request, active low.
- RD_N  output  1  read strobe, active low.
- WR_N  output  1  write strobe, active low.
- WAIT_N  input  1  wait request, active low.
- BUSY  output  1  FSM not in IDLE.

Behaviour:
- Reset values (asynchronous, held while RESET_N=0):
  - MREQ_N=RD_N=WR_N=1, D_OE=0.
  - Addr=0, D_OUT=0, RSP_RDATA=0.
  - RSP_VALID=0, RSP_TIMEOUT=0, BUSY=0.
  - REQ_READY=0 during reset, 1 in IDLE after reset.
- FSM states: IDLE, T1, T2, TW, T3. All outputs are registered.
- REQ_READY is 1 in IDLE, and in T3 (back-to-back issue). It is 0 otherwise.
- Accept rule: REQ_VALID & REQ_READY at an edge latches REQ_WR/ADDR/WDATA and moves to T1.
- T1:
  - Addr = latched address.
  - All strobes = 1.
  - D_OE = 1 for writes, with D_OUT = latched data.
- T2:
  - MREQ_N = 0.
  - Read: RD_N = 0.
  - Write: WR_N stays 1.
  - WAIT_N is sampled at the end of T2. If 0, go to TW; otherwise go to T3.
- TW:
  - Strobes as in T2.
  - Wait counter increments each TW cycle.
  - Stay in TW while WAIT_N=0 and counter < MAX_WAIT.
  - Exit to T3 when WAIT_N=1 or when counter == MAX_WAIT. The forced exit sets the timeout flag.
- T3:
  - MREQ_N = 0.
  - Read: RD_N = 0, and D_IN is captured into RSP_RDATA at the end of T3.
  - Write: WR_N = 0.
  - Next state is T1 if a request is accepted, else IDLE.
- RSP_VALID:
  - Pulses for exactly 1 cycle, in the cycle after T3.
  - RSP_TIMEOUT is valid in the same cycle and is 0 when RSP_VALID=0.
- Cycle latency (accept edge to RSP_VALID): 4 cycles with 0 waits, plus 1 per wait state.
- Strobe and drive invariants (never violated):
  - RD_N and WR_N are never both 0.
  - RD_N=0 or WR_N=0 implies MREQ_N=0.
  - D_OE=0 whenever RD_N=0.
- Strobe release between cycles:
  - In IDLE, all strobes are 1 and Addr holds its last value.
  - On back-to-back cycles, strobes return to 1 in the T1 of the next cycle.
- Reset mid-cycle: strobes deassert and D_OE drops immediately. No RSP_VALID is produced for the aborted request.
- Width: the wait counter saturates; it never wraps.

Optional Feature:
- Macro: Z80_WAIT_STATE_EN.
- Defined:
  - WAIT_N is honoured and TW exists.
  - MAX_WAIT timeout applies.
  - RSP_TIMEOUT is reported.
- Not defined:
  - WAIT_N is ignored and T2 always goes to T3.
  - RSP_TIMEOUT is tied to 0.
  - Every cycle is exactly 3 T-states; response arrives 4 cycles after accept.

Test Plan:
- Reset then idle → after RESET_N rises: MREQ_N=RD_N=WR_N=1, D_OE=0, REQ_READY=1, BUSY=0.
- Read REQ_ADDR=16'hB800, D_IN=8'h5A, WAIT_N=1:
  - Addr[15:11]=5'b10111 from T1.
  - MREQ_N=RD_N=0 in T2 and T3; WR_N=1 throughout.
  - RSP_VALID at accept+4 with RSP_RDATA=8'h5A, RSP_TIMEOUT=0.
- Write REQ_ADDR=16'hFFFF, WDATA=8'hC3:
  - D_OE=1 and D_OUT=8'hC3 from T1 through T3.
  - WR_N=0 only in T3; RD_N=1 always.
- Wait states (Z80_WAIT_STATE_EN defined):
  - Hold WAIT_N=0 for 2 cycles from T2 → exactly 2 TW cycles, RSP_VALID at accept+6, RSP_TIMEOUT=0.
  - Hold WAIT_N=0 permanently → forced exit after 15 TW cycles, RSP_TIMEOUT=1.
- Back-to-back (REQ_VALID held, read then write):
  - Second request accepted in T3.
  - All strobes high in the next T1.
  - Never RD_N=0 and WR_N=0 in the same cycle.
- Assert RESET_N=0 during TW of a read → strobes go to 1 asynchronously, no RSP_VALID pulse, REQ_READY=1 once reset is released.
